perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_counter_bank.sv | 139 +++++++++++++
 tb/tb_perf_counter_bank.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Performance counter bank: per-channel event counters plus a total-cycle
// counter, gated by a RUN/HALTED state machine, with a snapshot shadow bank
// and combinational readout through a channel select.
module perf_counter_bank #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned SATURATE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step,
  input  logic [CHANNELS-1:0] ev,
  input  logic                halt,
  input  logic                resume,
  input  logic                clr,
  input  logic                snap,
  input  logic [SEL_W-1:0]    sel,
  output logic [WIDTH-1:0]    count_out,
  output logic [WIDTH-1:0]    snap_out,
  output logic [WIDTH-1:0]    cycle_out,
  output logic [CHANNELS-1:0] ovf,
  output logic                halted
);

  typedef enum logic {StRun, StHalted} state_e;

  localparam logic [WIDTH-1:0] AllOnes = '1;

  state_e              r_state;
  logic                r_halted;
  logic [WIDTH-1:0]    r_cnt    [CHANNELS];
  logic [WIDTH-1:0]    r_shadow [CHANNELS];
  logic [WIDTH-1:0]    r_cycle;
  logic [CHANNELS-1:0] r_ovf;

  logic                w_count;
  logic [WIDTH-1:0]    w_cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] w_cnt_top;
  logic                w_cycle_top;
  logic [WIDTH-1:0]    w_cycle_nxt;

  // Counting happens only on a retired-cycle tick while running.
  assign w_count = (r_state == StRun) && step;

  // Incremented values with wrap or saturate at all-ones.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_cnt_top[i] = (r_cnt[i] == AllOnes);
      if (w_cnt_top[i]) begin
        w_cnt_nxt[i] = (SATURATE != 0) ? AllOnes : '0;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + WIDTH'(1);
      end
    end
    w_cycle_top = (r_cycle == AllOnes);
    if (w_cycle_top) begin
      w_cycle_nxt = (SATURATE != 0) ? AllOnes : '0;
    end else begin
      w_cycle_nxt = r_cycle + WIDTH'(1);
    end
  end

  // RUN/HALTED state machine with the halted flag registered alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StRun;
      r_halted <= 1'b0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (step && halt) begin
            r_state  <= StHalted;
            r_halted <= 1'b1;
          end
        end
        StHalted: begin
          if (resume) begin
            r_state  <= StRun;
            r_halted <= 1'b0;
          end
        end
      endcase
    end
  end

  // Counters, cycle count, sticky overflow and shadow bank.
  // Shadow captures pre-edge values, so it sees neither same-cycle clr nor increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_cnt[i]    <= '0;
        r_shadow[i] <= '0;
      end
      r_cycle <= '0;
      r_ovf   <= '0;
    end else begin
      if (snap) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          r_shadow[i] <= r_cnt[i];
        end
      end
      if (clr) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          r_cnt[i] <= '0;
        end
        r_cycle <= '0;
        r_ovf   <= '0;
      end else if (w_count) begin
        r_cycle <= w_cycle_nxt;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (ev[i]) begin
            r_cnt[i] <= w_cnt_nxt[i];
            if (w_cnt_top[i]) begin
              r_ovf[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Zero-latency readout; out-of-range selects read as zero.
  always_comb begin
    count_out = '0;
    snap_out  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (32'(sel) == i) begin
        count_out = r_cnt[i];
        snap_out  = r_shadow[i];
      end
    end
  end

  assign cycle_out = r_cycle;
  assign ovf       = r_ovf;
  assign halted    = r_halted;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank. Four instances share one stimulus:
// 16-bit wrap, 16-bit saturate, 3-bit wrap, 3-bit saturate.
module tb_perf_counter_bank;

  logic       clk = 1'b0;
  logic       rst, step, halt, resume, clr, snap;
  logic [3:0] ev;
  logic [3:0] sel;

  logic [15:0] o_cnt [4];
  logic [15:0] o_snp [4];
  logic [15:0] o_cyc [4];
  logic [3:0]  o_ovf [4];
  logic        o_hlt [4];

  logic [2:0] n0_cnt, n0_snp, n0_cyc, n1_cnt, n1_snp, n1_cyc;

  always #5 clk = ~clk;

  perf_counter_bank #(.WIDTH(16), .CHANNELS(4), .SEL_W(4), .SATURATE(0)) u_w16 (
    .clk(clk), .rst(rst), .step(step), .ev(ev), .halt(halt), .resume(resume), .clr(clr),
    .snap(snap), .sel(sel), .count_out(o_cnt[0]), .snap_out(o_snp[0]), .cycle_out(o_cyc[0]),
    .ovf(o_ovf[0]), .halted(o_hlt[0]));

  perf_counter_bank #(.WIDTH(16), .CHANNELS(4), .SEL_W(4), .SATURATE(1)) u_s16 (
    .clk(clk), .rst(rst), .step(step), .ev(ev), .halt(halt), .resume(resume), .clr(clr),
    .snap(snap), .sel(sel), .count_out(o_cnt[1]), .snap_out(o_snp[1]), .cycle_out(o_cyc[1]),
    .ovf(o_ovf[1]), .halted(o_hlt[1]));

  perf_counter_bank #(.WIDTH(3), .CHANNELS(4), .SEL_W(4), .SATURATE(0)) u_w3 (
    .clk(clk), .rst(rst), .step(step), .ev(ev), .halt(halt), .resume(resume), .clr(clr),
    .snap(snap), .sel(sel), .count_out(n0_cnt), .snap_out(n0_snp), .cycle_out(n0_cyc),
    .ovf(o_ovf[2]), .halted(o_hlt[2]));

  perf_counter_bank #(.WIDTH(3), .CHANNELS(4), .SEL_W(4), .SATURATE(1)) u_s3 (
    .clk(clk), .rst(rst), .step(step), .ev(ev), .halt(halt), .resume(resume), .clr(clr),
    .snap(snap), .sel(sel), .count_out(n1_cnt), .snap_out(n1_snp), .cycle_out(n1_cyc),
    .ovf(o_ovf[3]), .halted(o_hlt[3]));

  assign o_cnt[2] = {13'd0, n0_cnt};
  assign o_snp[2] = {13'd0, n0_snp};
  assign o_cyc[2] = {13'd0, n0_cyc};
  assign o_cnt[3] = {13'd0, n1_cnt};
  assign o_snp[3] = {13'd0, n1_snp};
  assign o_cyc[3] = {13'd0, n1_cyc};

  // Reference model: plain integer counters per instance.
  int unsigned m_max [4] = '{65535, 65535, 7, 7};
  bit          m_sat [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  int unsigned m_cnt [4][4];
  int unsigned m_shd [4][4];
  int unsigned m_cyc [4];
  bit          m_ovf [4][4];
  bit          m_halted;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic int unsigned bump(input int unsigned v, input int unsigned maxv,
                                       input bit sat, output bit o);
    if (v == maxv) begin
      o = 1'b1;
      return sat ? maxv : 0;
    end
    o = 1'b0;
    return v + 1;
  endfunction

  task automatic model_update();
    bit o;
    bit counting;
    counting = !m_halted && step;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_cyc[k] = 0;
        for (int c = 0; c < 4; c++) begin
          m_cnt[k][c] = 0;
          m_shd[k][c] = 0;
          m_ovf[k][c] = 1'b0;
        end
      end
      m_halted = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (snap) for (int c = 0; c < 4; c++) m_shd[k][c] = m_cnt[k][c];
        if (clr) begin
          m_cyc[k] = 0;
          for (int c = 0; c < 4; c++) begin
            m_cnt[k][c] = 0;
            m_ovf[k][c] = 1'b0;
          end
        end else if (counting) begin
          m_cyc[k] = bump(m_cyc[k], m_max[k], m_sat[k], o);
          for (int c = 0; c < 4; c++) begin
            if (ev[c]) begin
              m_cnt[k][c] = bump(m_cnt[k][c], m_max[k], m_sat[k], o);
              if (o) m_ovf[k][c] = 1'b1;
            end
          end
        end
      end
      if (counting && halt) m_halted = 1'b1;
      else if (m_halted && resume) m_halted = 1'b0;
    end
  endtask

  // One clock: model advances on the same inputs, outputs sampled 1ns after the edge.
  task automatic cyc();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    step = 0; ev = 0; halt = 0; resume = 0; clr = 0; snap = 0; rst = 0;
  endtask

  task automatic check_model();
    logic [3:0] eo;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) eo[c] = m_ovf[k][c];
      chk($sformatf("rnd%0d.cnt sel=%0d", k, sel), {16'd0, o_cnt[k]},
          (sel < 4) ? m_cnt[k][sel] : 0);
      chk($sformatf("rnd%0d.snap sel=%0d", k, sel), {16'd0, o_snp[k]},
          (sel < 4) ? m_shd[k][sel] : 0);
      chk($sformatf("rnd%0d.cycle", k), {16'd0, o_cyc[k]}, m_cyc[k]);
      chk($sformatf("rnd%0d.ovf", k), {28'd0, o_ovf[k]}, {28'd0, eo});
      chk($sformatf("rnd%0d.halted", k), {31'd0, o_hlt[k]}, {31'd0, m_halted});
    end
  endtask

  typedef struct {
    logic        step;
    logic [3:0]  ev;
    logic        halt, resume, clr, snap;
    logic [3:0]  sel;
    logic [15:0] e_cnt, e_snap, e_cyc;
    logic        e_h;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [3:0] e, input logic h,
                              input logic r, input logic c, input logic sn,
                              input logic [3:0] sl, input logic [15:0] ec,
                              input logic [15:0] es, input logic [15:0] ey, input logic eh);
    vec_t v;
    v.step = s; v.ev = e; v.halt = h; v.resume = r; v.clr = c; v.snap = sn; v.sel = sl;
    v.e_cnt = ec; v.e_snap = es; v.e_cyc = ey; v.e_h = eh;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];

    // Ten steps on channels 0 and 2, readout checks, snapshot, halt, clear, resume.
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1, 4'b0101, 0, 0, 0, 0, 0, 16'(i + 1), 0, 16'(i + 1), 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 2,  10, 0, 10, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1,  0,  0, 10, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 15, 0,  0, 10, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4,  0,  0, 10, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 1, 0,  11, 10, 11, 0));
    tbl.push_back(mk(1, 4'b0010, 1, 0, 0, 0, 1,  1,  0, 12, 1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 4'b1111, 0, 0, 0, 0, 1, 1, 0, 12, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 0, 0,  0,  10, 0, 1));
    tbl.push_back(mk(1, 4'b1111, 0, 1, 0, 0, 0,  0,  10, 0, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 0,  1,  10, 1, 0));
    tbl.push_back(mk(1, 4'b1111, 0, 0, 1, 0, 0,  0,  10, 0, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 0,  1,  10, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 0,  0,  1,  0, 0));

    idle();
    sel = 0;
    rst = 1;
    cyc();
    cyc();
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset%0d.cnt", k), {16'd0, o_cnt[k]}, 0);
      chk($sformatf("reset%0d.snap", k), {16'd0, o_snp[k]}, 0);
      chk($sformatf("reset%0d.cycle", k), {16'd0, o_cyc[k]}, 0);
      chk($sformatf("reset%0d.ovf", k), {28'd0, o_ovf[k]}, 0);
      chk($sformatf("reset%0d.halted", k), {31'd0, o_hlt[k]}, 0);
    end

    foreach (tbl[i]) begin
      step = tbl[i].step; ev = tbl[i].ev; halt = tbl[i].halt; resume = tbl[i].resume;
      clr = tbl[i].clr; snap = tbl[i].snap; sel = tbl[i].sel;
      cyc();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("vec%0d.%0d.cnt", i, k), {16'd0, o_cnt[k]}, {16'd0, tbl[i].e_cnt});
        chk($sformatf("vec%0d.%0d.snap", i, k), {16'd0, o_snp[k]}, {16'd0, tbl[i].e_snap});
        chk($sformatf("vec%0d.%0d.cycle", i, k), {16'd0, o_cyc[k]}, {16'd0, tbl[i].e_cyc});
        chk($sformatf("vec%0d.%0d.ovf", i, k), {28'd0, o_ovf[k]}, 0);
        chk($sformatf("vec%0d.%0d.halted", i, k), {31'd0, o_hlt[k]}, {31'd0, tbl[i].e_h});
      end
    end

    // Counter at 7, snap together with a counted event.
    idle(); sel = 0; clr = 1; cyc(); idle();
    step = 1; ev = 4'b0001;
    for (int i = 0; i < 7; i++) cyc();
    snap = 1;
    cyc();
    idle();
    chk("snap_same_cycle.snap", {16'd0, o_snp[0]}, 7);
    chk("snap_same_cycle.cnt", {16'd0, o_cnt[0]}, 8);

    // Drive channel 0 to all-ones, then one more event: wrap vs saturate.
    clr = 1; cyc(); idle();
    step = 1; ev = 4'b0001;
    for (int i = 0; i < 65535; i++) cyc();
    chk("preload.w16.cnt", {16'd0, o_cnt[0]}, 32'hFFFF);
    chk("preload.w16.ovf", {28'd0, o_ovf[0]}, 0);
    cyc();
    chk("wrap.cnt", {16'd0, o_cnt[0]}, 0);
    chk("wrap.ovf", {28'd0, o_ovf[0]}, 1);
    chk("wrap.cycle", {16'd0, o_cyc[0]}, 0);
    chk("sat.cnt", {16'd0, o_cnt[1]}, 32'hFFFF);
    chk("sat.ovf", {28'd0, o_ovf[1]}, 1);
    chk("sat.cycle", {16'd0, o_cyc[1]}, 32'hFFFF);
    cyc();
    chk("wrap_sticky.cnt", {16'd0, o_cnt[0]}, 1);
    chk("wrap_sticky.ovf", {28'd0, o_ovf[0]}, 1);
    chk("sat_sticky.cnt", {16'd0, o_cnt[1]}, 32'hFFFF);

    // Reset while halted with nonzero counters and shadow, all other controls active.
    idle(); step = 1; halt = 1; snap = 1; ev = 4'b1111; cyc();
    idle();
    chk("pre_rst.halted", {31'd0, o_hlt[0]}, 1);
    rst = 1; clr = 1; snap = 1; step = 1; resume = 1; ev = 4'b1111;
    cyc();
    idle();
    chk("rst.halted", {31'd0, o_hlt[0]}, 0);
    chk("rst.cycle", {16'd0, o_cyc[0]}, 0);
    chk("rst.ovf", {28'd0, o_ovf[0]}, 0);
    for (int s = 0; s < 4; s++) begin
      sel = 4'(s);
      #1;
      chk($sformatf("rst.cnt%0d", s), {16'd0, o_cnt[0]}, 0);
      chk($sformatf("rst.snap%0d", s), {16'd0, o_snp[0]}, 0);
    end

    // Randomized traffic against the reference model on all instances.
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(99) == 0);
      clr    = ($urandom_range(31) == 0);
      snap   = ($urandom_range(7) == 0);
      step   = ($urandom_range(1) == 0);
      halt   = ($urandom_range(9) == 0);
      resume = ($urandom_range(3) == 0);
      ev     = 4'($urandom_range(15));
      sel    = 4'($urandom_range(15));
      cyc();
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
